// File: rtl/block_luma_stat_if.sv
// block_luma_stat_if: per-block luma record bus from the stats collector to the dimming algorithm
interface block_luma_stat_if #(parameter int YW = 8, SUMW = 20, CNTW = 12, VAW = 4);
  logic valid;
  logic ready;
  logic [VAW-1:0] vaddr;
  logic [4:0] hidx;
  logic [YW-1:0] maxY;
  logic [SUMW-1:0] sum;
  logic [CNTW-1:0] cnt;
  modport master(output valid, vaddr, hidx, maxY, sum, cnt, input ready);
  modport slave(input valid, vaddr, hidx, maxY, sum, cnt, output ready);
endinterface

// File: rtl/block_luma_stat.sv
// block_luma_stat: per-block max/sum/count of Y for each band, drained as NBLK records at band end
module block_luma_stat #(
  parameter int NBLK = 24,
  parameter int YW = 8,
  parameter int SUMW = 20,
  parameter int CNTW = 12,
  parameter int VAW = 4
) (
  input  logic iODCK,
  input  logic iRST_n,
  input  logic iALG_rst,
  input  logic [NBLK-1:0] iH_Duty,
  input  logic iV_Duty,
  input  logic [NBLK*YW-1:0] iPixelData,
  input  logic [VAW-1:0] iV_Address,
  input  logic iOU_en,
  block_luma_stat_if.master stat,
  output logic oBusy,
  output logic oOverrun
);
  localparam logic [4:0] LAST = 5'(NBLK - 1);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state;
  logic [YW-1:0] accMax [NBLK];
  logic [YW-1:0] nxtMax [NBLK];
  logic [YW-1:0] shMax [NBLK];
  logic [SUMW-1:0] accSum [NBLK];
  logic [SUMW-1:0] nxtSum [NBLK];
  logic [SUMW-1:0] shSum [NBLK];
  logic [CNTW-1:0] accCnt [NBLK];
  logic [CNTW-1:0] nxtCnt [NBLK];
  logic [CNTW-1:0] shCnt [NBLK];
  logic [4:0] nIdx;
  assign nIdx = stat.hidx + 5'd1;
  for (genvar k = 0; k < NBLK; k++) begin : gLane
    logic [YW-1:0] y;
    logic hit;
    logic [SUMW:0] s;
    logic [CNTW:0] c;
    assign y = iPixelData[k*YW +: YW];
    assign hit = iV_Duty & iH_Duty[k];
    assign s = {1'b0, accSum[k]} + (SUMW+1)'(y);
    assign c = {1'b0, accCnt[k]} + (CNTW+1)'(1);
    // the extra top bit of s/c is the carry that pins the value at all-ones
    assign nxtMax[k] = (hit && y > accMax[k]) ? y : accMax[k];
    assign nxtSum[k] = !hit ? accSum[k] : s[SUMW] ? '1 : s[SUMW-1:0];
    assign nxtCnt[k] = !hit ? accCnt[k] : c[CNTW] ? '1 : c[CNTW-1:0];
  end
  always_ff @(posedge iODCK or negedge iRST_n)
    if (!iRST_n) begin
      accMax <= '{default: '0};
      accSum <= '{default: '0};
      accCnt <= '{default: '0};
      shMax <= '{default: '0};
      shSum <= '{default: '0};
      shCnt <= '{default: '0};
    end else if (iALG_rst) begin
      accMax <= '{default: '0};
      accSum <= '{default: '0};
      accCnt <= '{default: '0};
      shMax <= '{default: '0};
      shSum <= '{default: '0};
      shCnt <= '{default: '0};
    end else if (iOU_en) begin
      accMax <= '{default: '0};
      accSum <= '{default: '0};
      accCnt <= '{default: '0};
      shMax <= nxtMax;
      shSum <= nxtSum;
      shCnt <= nxtCnt;
    end else begin
      accMax <= nxtMax;
      accSum <= nxtSum;
      accCnt <= nxtCnt;
    end
  // record 0 is loaded straight from the next-state values since the shadow fills on the same edge
  always_ff @(posedge iODCK or negedge iRST_n)
    if (!iRST_n) begin
      state <= IDLE;
      stat.valid <= 1'b0;
      stat.vaddr <= '0;
      stat.hidx <= '0;
      stat.maxY <= '0;
      stat.sum <= '0;
      stat.cnt <= '0;
      oBusy <= 1'b0;
      oOverrun <= 1'b0;
    end else if (iALG_rst) begin
      state <= IDLE;
      stat.valid <= 1'b0;
      stat.hidx <= '0;
      oBusy <= 1'b0;
    end else if (iOU_en) begin
      oOverrun <= oOverrun | (state == DRAIN);
      state <= DRAIN;
      stat.valid <= 1'b1;
      stat.vaddr <= iV_Address;
      stat.hidx <= '0;
      stat.maxY <= nxtMax[0];
      stat.sum <= nxtSum[0];
      stat.cnt <= nxtCnt[0];
      oBusy <= 1'b1;
    end else if (state == DRAIN && stat.ready) begin
      if (stat.hidx == LAST) begin
        state <= IDLE;
        stat.valid <= 1'b0;
        oBusy <= 1'b0;
      end else begin
        stat.hidx <= nIdx;
        stat.maxY <= shMax[nIdx];
        stat.sum <= shSum[nIdx];
        stat.cnt <= shCnt[nIdx];
      end
    end
endmodule

// File: tb/tb_block_luma_stat.sv
// tb_block_luma_stat: scoreboard bench; a band model predicts each drained record
module tb_block_luma_stat;
  localparam int NBLK = 24, YW = 8, SUMW = 20, CNTW = 12, VAW = 4;
  typedef struct packed {
    logic [3:0] vaddr;
    logic [4:0] hidx;
    logic [7:0] maxY;
    logic [19:0] sum;
    logic [11:0] cnt;
  } rec_t;
  logic clk = 1'b0;
  logic rstN, algRst, vDuty, ouEn, busy, overrun;
  logic [NBLK-1:0] hDuty;
  logic [NBLK*YW-1:0] pix;
  logic [VAW-1:0] vAddr;
  int checks = 0, errors = 0;
  int mMax [NBLK], mSum [NBLK], mCnt [NBLK];
  rec_t q [$];
  rec_t prevRec;
  bit prevStall = 0, expOvr = 0, toggleReady = 0;
  block_luma_stat_if #(.YW(YW), .SUMW(SUMW), .CNTW(CNTW), .VAW(VAW)) st();
  block_luma_stat #(.NBLK(NBLK), .YW(YW), .SUMW(SUMW), .CNTW(CNTW), .VAW(VAW)) dut (
    .iODCK(clk), .iRST_n(rstN), .iALG_rst(algRst), .iH_Duty(hDuty), .iV_Duty(vDuty),
    .iPixelData(pix), .iV_Address(vAddr), .iOU_en(ouEn), .stat(st), .oBusy(busy),
    .oOverrun(overrun)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic clearModel();
    for (int k = 0; k < NBLK; k++) begin
      mMax[k] = 0;
      mSum[k] = 0;
      mCnt[k] = 0;
    end
  endtask
  task automatic cycle();
    bit act;
    rec_t r;
    int y;
    @(negedge clk);
    act = q.size() != 0;
    if (prevStall) begin
      chk("hold_hidx", st.hidx, prevRec.hidx);
      chk("hold_sum", st.sum, prevRec.sum);
    end
    prevStall = st.valid && !st.ready && !ouEn && !algRst;
    prevRec = '{st.vaddr, st.hidx, st.maxY, st.sum, st.cnt};
    if (st.valid && st.ready) begin
      if (q.size() == 0) chk("unexpected_rec", st.valid, 0);
      else begin
        r = q.pop_front();
        chk("vaddr", st.vaddr, r.vaddr);
        chk("hidx", st.hidx, r.hidx);
        chk("max", st.maxY, r.maxY);
        chk("sum", st.sum, r.sum);
        chk("cnt", st.cnt, r.cnt);
      end
    end
    for (int k = 0; k < NBLK; k++)
      if (vDuty && hDuty[k]) begin
        y = int'(pix[k*YW +: YW]);
        if (y > mMax[k]) mMax[k] = y;
        mSum[k] = (mSum[k] + y > 1048575) ? 1048575 : mSum[k] + y;
        mCnt[k] = (mCnt[k] + 1 > 4095) ? 4095 : mCnt[k] + 1;
      end
    if (algRst) begin
      clearModel();
      q.delete();
    end else if (ouEn) begin
      if (act) expOvr = 1;
      q.delete();
      for (int k = 0; k < NBLK; k++)
        q.push_back('{vAddr, 5'(k), 8'(mMax[k]), 20'(mSum[k]), 12'(mCnt[k])});
      clearModel();
    end
    @(posedge clk);
    #1;
    if (toggleReady) st.ready = ~st.ready;
  endtask
  task automatic idle(int n);
    hDuty = '0;
    vDuty = 1'b0;
    ouEn = 1'b0;
    repeat (n) cycle();
  endtask
  task automatic pulseOu(logic [VAW-1:0] a);
    hDuty = '0;
    vDuty = 1'b0;
    vAddr = a;
    ouEn = 1'b1;
    cycle();
    ouEn = 1'b0;
  endtask
  task automatic randBand(int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NBLK; k++) pix[k*YW +: YW] = 8'($urandom);
      hDuty = 24'($urandom);
      vDuty = ($urandom_range(3) != 0);
      cycle();
    end
    hDuty = '0;
    vDuty = 1'b0;
  endtask
  task automatic drainWait(string tag);
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle();
    chk({tag, "_left"}, q.size(), 0);
    idle(2);
    chk({tag, "_valid_low"}, st.valid, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_overrun"}, overrun, expOvr);
  endtask
  initial begin
    rstN = 1'b0;
    algRst = 1'b0;
    ouEn = 1'b0;
    vDuty = 1'b0;
    hDuty = '0;
    pix = '0;
    vAddr = '0;
    st.ready = 1'b0;
    clearModel();
    #3;
    chk("rst_valid", st.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sum", st.sum, 0);
    #9 rstN = 1'b1;
    @(posedge clk);
    #1;
    st.ready = 1'b1;
    idle(3);
    chk("idle_valid", st.valid, 0);
    // T2: one block per cycle, 40 px x 2 lines each, Y = 10k+5
    for (int k = 0; k < NBLK; k++) pix[k*YW +: YW] = 8'(10 * k + 5);
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < NBLK; k++) begin
        hDuty = '0;
        hDuty[k] = 1'b1;
        vDuty = 1'b1;
        repeat (40) cycle();
      end
      idle(3);
    end
    pulseOu(4'd3);
    chk("t2_first_valid", st.valid, 1);
    chk("t2_first_busy", busy, 1);
    chk("t2_first_sum", st.sum, 400);
    chk("t2_first_cnt", st.cnt, 80);
    drainWait("t2");
    // T3: backpressure with ready alternating
    randBand(300);
    toggleReady = 1;
    pulseOu(4'd7);
    drainWait("t3");
    toggleReady = 0;
    st.ready = 1'b1;
    // T4: block 0 saturates count and sum
    for (int k = 0; k < NBLK; k++) pix[k*YW +: YW] = 8'($urandom);
    pix[YW-1:0] = 8'hff;
    hDuty = 24'd1;
    vDuty = 1'b1;
    repeat (4200) cycle();
    pulseOu(4'd1);
    chk("t4_cnt", st.cnt, 4095);
    chk("t4_sum", st.sum, 1048575);
    chk("t4_max", st.maxY, 255);
    drainWait("t4");
    // T5: second band-done arrives while record 10 is on the bus
    randBand(100);
    pulseOu(4'd5);
    randBand(10);
    chk("t5_pre_hidx", st.hidx, 10);
    vAddr = 4'd6;
    ouEn = 1'b1;
    cycle();
    ouEn = 1'b0;
    chk("t5_overrun", overrun, 1);
    chk("t5_restart_hidx", st.hidx, 0);
    chk("t5_restart_vaddr", st.vaddr, 6);
    drainWait("t5");
    // T1: async reset mid-drain
    randBand(50);
    pulseOu(4'd2);
    idle(5);
    #2 rstN = 1'b0;
    #1;
    chk("t1_valid", st.valid, 0);
    chk("t1_hidx", st.hidx, 0);
    chk("t1_max", st.maxY, 0);
    chk("t1_cnt", st.cnt, 0);
    chk("t1_busy", busy, 0);
    chk("t1_overrun", overrun, 0);
    q.delete();
    clearModel();
    expOvr = 0;
    prevStall = 0;
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    @(posedge clk);
    #1;
    idle(10);
    chk("t1_no_rec", st.valid, 0);
    // T6: frame restart beats band-done in the same cycle
    randBand(50);
    algRst = 1'b1;
    ouEn = 1'b1;
    vAddr = 4'd9;
    cycle();
    algRst = 1'b0;
    ouEn = 1'b0;
    idle(5);
    chk("t6_no_drain", st.valid, 0);
    for (int k = 0; k < NBLK; k++) pix[k*YW +: YW] = 8'(k + 1);
    hDuty = 24'h8;
    vDuty = 1'b1;
    repeat (7) cycle();
    pulseOu(4'd4);
    chk("t6_first_cnt", st.cnt, 0);
    drainWait("t6");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
